laser_tx_scheduler: RTL and testbench
=====================================

Name: laser_tx_scheduler

Overview:
- Transmit-side controller that drains the byte queue (8-bit Q, read strobe, size/empty status) and drives the laser line.
- Waits until a full packet's worth of bytes is queued. Then emits one packet: a preamble frame, PACKET_BYTES payload frames, an XOR checksum frame, and an idle gap.
- Each frame is UART-style: start bit 0, 8 data bits LSB first, stop bit 1.
- Sits between the queue and the laser driver pin. It is the only agent that asserts the queue's read strobe.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per transmitted bit; must be >= 2.
- PACKET_BYTES, 8, payload bytes per packet; range 1..64.
- GAP_BITS, 4, idle-high bit times after the checksum frame.
- PREAMBLE, 8'hA5, value of the first frame of every packet.

Ports:
- clock, input, 1, system clock, rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- enable, input, 1, permits a new packet to start; sampled only in IDLE.
- q_data, input, 8, queue head byte; combinational and valid whenever q_empty=0.
- q_size, input, 8, number of bytes currently in the queue.
- q_empty, input, 1, queue empty flag.
- q_read, output, 1, one-cycle pop strobe to the queue.
- laser_out, output, 1, registered laser line; idle level is 1.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse when a packet completes normally.
- underrun, output, 1, one-cycle pulse when a packet is aborted because the queue was empty.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, laser_out=1, q_read=0, busy=0, done=0, underrun=0. Counters and checksum are cleared.
- States: IDLE, LOAD, SEND, GAP.
- IDLE:
  - If enable=1 and q_size >= PACKET_BYTES: go to LOAD and clear byte_idx and checksum.
  - laser_out=1.
- LOAD (exactly 1 cycle, laser_out=1):
  - Selects the next frame byte:
    - byte_idx=0: PREAMBLE.
    - byte_idx=1..PACKET_BYTES: q_data. In this case q_read=1 in this same cycle, and checksum ^= q_data.
    - byte_idx=PACKET_BYTES+1: checksum.
  - Latches the frame {1, byte, 0} into a 10-bit shift register, then goes to SEND.
  - Payload byte with q_empty=1: no q_read, pulse underrun, go to GAP. No checksum frame is sent.
- SEND:
  - laser_out = current frame bit; each bit is held exactly CLKS_PER_BIT cycles.
  - After 10 bits: byte_idx++. If byte_idx was PACKET_BYTES+1, go to GAP; otherwise go to LOAD.
- GAP: laser_out=1 for GAP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
  - done=1 on the transition cycle into IDLE after a normal packet.
  - done stays 0 on the transition after an underrun abort.
- Timing:
  - laser_out is registered: the first start bit appears 2 cycles after IDLE sees the start condition (1 LOAD cycle plus 1 register stage).
  - Slot length = 1 + 10*CLKS_PER_BIT cycles.
  - Packet length = (PACKET_BYTES+2)*slot + GAP_BITS*CLKS_PER_BIT cycles.
- q_read: exactly PACKET_BYTES pulses per normal packet, never two in consecutive cycles, never while q_empty=1.
- Checksum: 8-bit XOR of payload bytes only (the preamble is excluded).
- enable deasserted mid-packet: ignored; the current packet completes. enable is rechecked only in IDLE.
- Back-to-back packets: IDLE holds for at least 1 cycle between packets, even if the start condition is true continuously.
- reset_n asserted mid-packet: immediate return to reset values. The partial frame is truncated with laser_out=1. Bytes already popped are not restored.
- q_size is compared as unsigned 8 bits.

Test Plan:
- Setup for all scenarios: CLKS_PER_BIT=4, PACKET_BYTES=4, GAP_BITS=2. Each slot is 41 cycles.
- Queue preloaded 01,02,03,04, enable=1 -> 6 frames A5,01,02,03,04,04 (checksum 04). Exactly 4 q_read pulses. done pulses 254 cycles after start. busy high throughout.
- q_size=3, enable=1 -> stays IDLE, laser_out=1, no q_read. Push a 4th byte -> packet starts next cycle.
- Queue of 4 bytes, external clear drops q_empty=1 before the 3rd payload LOAD -> underrun pulse, no checksum frame, GAP then IDLE, done=0.
- enable dropped during the 2nd payload frame -> packet completes with done. With 8 bytes still queued, no new packet starts until enable=1.
- reset_n pulsed low mid-SEND of byte 02 -> laser_out=1, busy=0, q_read=0 asynchronously. After release, a fresh packet starts from the preamble.
- Payload FF,00,FF,00 -> checksum 00. Verify LSB-first bit order and 4-cycle bit width on laser_out.

Source files
------------

// File: rtl/laser_tx_scheduler_if.sv
// laser_tx_scheduler_if: byte-queue read port between the transmit scheduler
// and the transmit byte queue.
//   q_data  - queue head byte, valid whenever q_empty is low
//   q_size  - number of bytes currently queued (unsigned)
//   q_empty - queue empty flag
//   q_read  - one-cycle pop strobe, driven only by the scheduler
// Modports: master = scheduler side, slave = queue side.
interface laser_tx_scheduler_if;
  logic [7:0] q_data;
  logic [7:0] q_size;
  logic       q_empty;
  logic       q_read;

  modport master (
    input  q_data,
    input  q_size,
    input  q_empty,
    output q_read
  );

  modport slave (
    output q_data,
    output q_size,
    output q_empty,
    input  q_read
  );
endinterface

// File: rtl/laser_tx_scheduler.sv
// laser_tx_scheduler: drains the transmit byte queue and serialises one packet
// onto the laser line once a full packet's worth of bytes is queued.
// Packet = preamble frame, PACKET_BYTES payload frames, XOR checksum frame,
// then GAP_BITS idle bit times. Each frame is start 0, 8 data bits LSB first,
// stop 1, every bit held CLKS_PER_BIT cycles, preceded by one LOAD cycle.
// Ports:
//   clock     - system clock, rising edge
//   reset_n   - asynchronous active-low reset
//   enable    - permits a new packet to start (only looked at in IDLE)
//   qif       - queue read port (q_data/q_size/q_empty in, q_read out)
//   laser_out - registered laser line, idle level 1
//   busy      - high in every state except IDLE
//   done      - one-cycle pulse when a packet completes normally
//   underrun  - one-cycle pulse when a packet is aborted on an empty queue
// Parameter limits: CLKS_PER_BIT >= 2, PACKET_BYTES 1..64, GAP_BITS >= 1.
module laser_tx_scheduler #(
  parameter int         CLKS_PER_BIT = 4,
  parameter int         PACKET_BYTES = 8,
  parameter int         GAP_BITS     = 4,
  parameter logic [7:0] PREAMBLE     = 8'hA5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  laser_tx_scheduler_if.master qif,
  output logic                 laser_out,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  localparam int                CLK_W      = $clog2(CLKS_PER_BIT);
  localparam logic [CLK_W-1:0]  CLK_LAST   = CLK_W'(CLKS_PER_BIT - 1);
  localparam int                GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
  localparam int                GAP_W      = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [6:0]        IDX_CHK    = 7'(PACKET_BYTES + 1);
  localparam logic [7:0]        NEED_BYTES = 8'(PACKET_BYTES);

  // Running checksum update: plain XOR fold of one payload byte.
  function automatic logic [7:0] xor_accum(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

  logic [1:0]       state_r;
  logic [6:0]       idx_r;       // frame index within packet: 0 preamble, 1..N payload, N+1 checksum
  logic [7:0]       chk_r;
  logic [8:0]       shreg_r;     // frame bits still to send after the start bit: data LSB first, then stop
  logic [CLK_W-1:0] clk_cnt_r;
  logic [3:0]       bit_cnt_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic             aborted_r;
  logic             laser_r;
  logic             busy_r;
  logic             done_r;
  logic             underrun_r;

  logic             start_s;
  logic             idx_is_pre_s;
  logic             idx_is_chk_s;
  logic             idx_is_pay_s;
  logic [7:0]       frame_byte_s;

  assign start_s      = enable && (qif.q_size >= NEED_BYTES);
  assign idx_is_pre_s = (idx_r == 7'd0);
  assign idx_is_chk_s = (idx_r == IDX_CHK);
  assign idx_is_pay_s = !idx_is_pre_s && !idx_is_chk_s;

  // The pop must coincide with the LOAD cycle that samples q_data, so the
  // strobe is decoded from registered state rather than registered itself.
  assign qif.q_read = (state_r == ST_LOAD) && idx_is_pay_s && !qif.q_empty;

  assign laser_out = laser_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign underrun  = underrun_r;

  // Selects the byte carried by the frame about to be loaded.
  always_comb begin
    frame_byte_s = PREAMBLE;
    if (idx_is_pre_s) begin
      frame_byte_s = PREAMBLE;
    end else if (idx_is_chk_s) begin
      frame_byte_s = chk_r;
    end else begin
      frame_byte_s = qif.q_data;
    end
  end

  // Packet sequencer: state, counters, shift register and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= 7'd0;
      chk_r      <= 8'h00;
      shreg_r    <= 9'h1FF;
      clk_cnt_r  <= '0;
      bit_cnt_r  <= 4'd0;
      gap_cnt_r  <= '0;
      aborted_r  <= 1'b0;
      laser_r    <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      underrun_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          laser_r <= 1'b1;
          if (start_s) begin
            state_r   <= ST_LOAD;
            busy_r    <= 1'b1;
            idx_r     <= 7'd0;
            chk_r     <= 8'h00;
            aborted_r <= 1'b0;
          end
        end
        ST_LOAD: begin
          clk_cnt_r <= '0;
          bit_cnt_r <= 4'd0;
          if (idx_is_pay_s && qif.q_empty) begin
            // Queue ran dry mid-packet: drop the rest, no checksum frame.
            state_r    <= ST_GAP;
            gap_cnt_r  <= '0;
            aborted_r  <= 1'b1;
            underrun_r <= 1'b1;
            laser_r    <= 1'b1;
          end else begin
            state_r <= ST_SEND;
            shreg_r <= {1'b1, frame_byte_s};
            laser_r <= 1'b0;  // start bit goes out with the first SEND cycle
            if (idx_is_pay_s) begin
              chk_r <= xor_accum(chk_r, qif.q_data);
            end
          end
        end
        ST_SEND: begin
          if (clk_cnt_r == CLK_LAST) begin
            clk_cnt_r <= '0;
            if (bit_cnt_r == 4'd9) begin
              laser_r   <= 1'b1;
              idx_r     <= idx_r + 7'd1;
              bit_cnt_r <= 4'd0;
              if (idx_is_chk_s) begin
                state_r   <= ST_GAP;
                gap_cnt_r <= '0;
              end else begin
                state_r <= ST_LOAD;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
              laser_r   <= shreg_r[0];
              shreg_r   <= {1'b1, shreg_r[8:1]};
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CLK_W'(1);
          end
        end
        ST_GAP: begin
          laser_r <= 1'b1;
          if (gap_cnt_r == GAP_LAST) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            done_r    <= !aborted_r;
            gap_cnt_r <= '0;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          laser_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_laser_tx_scheduler.sv
// tb_laser_tx_scheduler: self-checking bench for laser_tx_scheduler.
// A queue model feeds the read port; per-cycle samples of
// {laser_out, busy, done, underrun, q_read} are compared against a packet
// model built from the framing rules.
module tb_laser_tx_scheduler;
  localparam int         CPB  = 4;
  localparam int         PB   = 4;
  localparam int         GB   = 2;
  localparam logic [7:0] PRE  = 8'hA5;
  localparam int         SLOT = 1 + 10 * CPB;
  localparam int         PKT  = (PB + 2) * SLOT + GB * CPB;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  logic enable  = 1'b0;
  logic laser_out, busy, done, underrun;

  laser_tx_scheduler_if qif();

  laser_tx_scheduler #(
    .CLKS_PER_BIT(CPB), .PACKET_BYTES(PB), .GAP_BITS(GB), .PREAMBLE(PRE)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .qif(qif),
    .laser_out(laser_out), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clock = ~clock;

  int n_checks;
  int n_fail;
  logic [7:0] qmem[$];
  logic [4:0] s_smp[$];
  logic [4:0] exp_smp[$];

  function automatic void drive_q();
    qif.q_size  = 8'(qmem.size());
    qif.q_empty = (qmem.size() == 0);
    qif.q_data  = (qmem.size() != 0) ? qmem[0] : 8'h00;
  endfunction

  // Queue side: pop on the strobe, present the new head a little after the edge.
  always @(posedge clock) begin
    if (qif.q_read === 1'b1 && qmem.size() != 0) void'(qmem.pop_front());
    #1 drive_q();
  end

  function automatic void push_exp(input logic las, input logic bsy, input logic dn,
                                   input logic ur, input logic qr);
    exp_smp.push_back({las, bsy, dn, ur, qr});
  endfunction

  // Packet model: 'pay' holds the payload bytes actually read; abort means the
  // next payload LOAD found the queue empty.
  function automatic void model_packet(input logic [7:0] pay[$], input bit abort);
    logic [7:0] frames[$];
    logic [7:0] chk;
    logic [7:0] tmp;
    logic       v;
    bit         is_pay;
    chk = 8'h00;
    frames.push_back(PRE);
    foreach (pay[i]) begin
      frames.push_back(pay[i]);
      chk = chk ^ pay[i];
    end
    if (!abort) frames.push_back(chk);
    foreach (frames[j]) begin
      is_pay = (j != 0) && (abort || j != frames.size() - 1);
      push_exp(1'b1, 1'b1, 1'b0, 1'b0, is_pay);
      for (int b = 0; b < 10; b++) begin
        if (b == 0) v = 1'b0;
        else if (b == 9) v = 1'b1;
        else begin
          tmp = frames[j] >> (b - 1);
          v = tmp[0];
        end
        for (int c = 0; c < CPB; c++) push_exp(v, 1'b1, 1'b0, 1'b0, 1'b0);
      end
    end
    if (abort) push_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int g = 0; g < GB * CPB; g++) push_exp(1'b1, 1'b1, 1'b0, abort && (g == 0), 1'b0);
    push_exp(1'b1, 1'b0, !abort, 1'b0, 1'b0);
  endfunction

  task automatic capture(input int n, input int drop_en_at, input int clear_at);
    s_smp.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      s_smp.push_back({laser_out, busy, done, underrun, qif.q_read});
      if (i == drop_en_at) enable = 1'b0;
      if (i == clear_at) begin
        qmem.delete();
        drive_q();
      end
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clock);
    while (busy !== 1'b0 && k < 600) begin
      @(negedge clock);
      k++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, k);
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    n_checks++;
    if ({laser_out, busy, done, underrun, qif.q_read} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_values: got %b want 10000", {laser_out, busy, done, underrun, qif.q_read});
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({laser_out, busy, done, underrun, qif.q_read} !== 5'b10000) begin
      n_fail++;
      $display("FAIL after_release: got %b want 10000", {laser_out, busy, done, underrun, qif.q_read});
    end
  endtask

  task automatic test_basic();
    logic [7:0] pay[$];
    int errs, first;
    pay = {8'h01, 8'h02, 8'h03, 8'h04};
    qmem = pay;
    drive_q();
    enable = 1'b1;
    exp_smp.delete();
    model_packet(pay, 1'b0);
    capture(exp_smp.size(), -1, -1);
    enable = 1'b0;
    errs = 0; first = -1;
    foreach (exp_smp[i]) if (s_smp[i] !== exp_smp[i]) begin if (first < 0) first = i; errs++; end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL basic_wave: %0d bad cycles, first %0d got %b want %b", errs, first, s_smp[first], exp_smp[first]);
    end
    n_checks++;
    if (s_smp[PKT] !== 5'b10100) begin
      n_fail++;
      $display("FAIL basic_done_latency: cycle %0d got %b want 10100", PKT, s_smp[PKT]);
    end
    n_checks++;
    if (qmem.size() != 0) begin
      n_fail++;
      $display("FAIL basic_pops: %0d bytes left, want 0", qmem.size());
    end
    wait_idle();
  endtask

  task automatic test_idle_hold();
    logic [7:0] pay[$];
    int errs, first;
    pay.delete();
    for (int i = 0; i < 4; i++) pay.push_back(8'($urandom_range(0, 255)));
    qmem.delete();
    for (int i = 0; i < 3; i++) qmem.push_back(pay[i]);
    drive_q();
    enable = 1'b1;
    capture(20, -1, -1);
    errs = 0;
    foreach (s_smp[i]) if (s_smp[i] !== 5'b10000) errs++;
    n_checks++;
    if (errs != 0 || qmem.size() != 3) begin
      n_fail++;
      $display("FAIL idle_short_queue: %0d non-idle cycles, %0d bytes left, want 0 and 3", errs, qmem.size());
    end
    qmem.push_back(pay[3]);
    drive_q();
    exp_smp.delete();
    model_packet(pay, 1'b0);
    capture(exp_smp.size(), -1, -1);
    enable = 1'b0;
    errs = 0; first = -1;
    foreach (exp_smp[i]) if (s_smp[i] !== exp_smp[i]) begin if (first < 0) first = i; errs++; end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL idle_then_start: %0d bad cycles, first %0d got %b want %b", errs, first, s_smp[first], exp_smp[first]);
    end
    wait_idle();
  endtask

  task automatic test_underrun();
    logic [7:0] pay[$];
    int errs, first;
    qmem.delete();
    for (int i = 0; i < 4; i++) qmem.push_back(8'($urandom_range(0, 255)));
    pay = {qmem[0], qmem[1]};
    drive_q();
    enable = 1'b1;
    exp_smp.delete();
    model_packet(pay, 1'b1);
    capture(exp_smp.size(), -1, 100);
    enable = 1'b0;
    errs = 0; first = -1;
    foreach (exp_smp[i]) if (s_smp[i] !== exp_smp[i]) begin if (first < 0) first = i; errs++; end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL underrun_wave: %0d bad cycles, first %0d got %b want %b", errs, first, s_smp[first], exp_smp[first]);
    end
    wait_idle();
  endtask

  task automatic test_enable_drop();
    logic [7:0] all[$];
    logic [7:0] pay[$];
    int errs, first;
    all.delete();
    for (int i = 0; i < 12; i++) all.push_back(8'($urandom_range(0, 255)));
    qmem = all;
    drive_q();
    enable = 1'b1;
    pay.delete();
    for (int i = 0; i < 4; i++) pay.push_back(all[i]);
    exp_smp.delete();
    model_packet(pay, 1'b0);
    capture(exp_smp.size(), 2 * SLOT + 8, -1);
    errs = 0; first = -1;
    foreach (exp_smp[i]) if (s_smp[i] !== exp_smp[i]) begin if (first < 0) first = i; errs++; end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL en_drop_wave: %0d bad cycles, first %0d got %b want %b", errs, first, s_smp[first], exp_smp[first]);
    end
    capture(20, -1, -1);
    errs = 0;
    foreach (s_smp[i]) if (s_smp[i] !== 5'b10000) errs++;
    n_checks++;
    if (errs != 0 || qmem.size() != 8) begin
      n_fail++;
      $display("FAIL en_drop_hold: %0d non-idle cycles, %0d bytes left, want 0 and 8", errs, qmem.size());
    end
    enable = 1'b1;
    pay.delete();
    for (int i = 4; i < 8; i++) pay.push_back(all[i]);
    exp_smp.delete();
    model_packet(pay, 1'b0);
    capture(exp_smp.size(), -1, -1);
    enable = 1'b0;
    errs = 0; first = -1;
    foreach (exp_smp[i]) if (s_smp[i] !== exp_smp[i]) begin if (first < 0) first = i; errs++; end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL en_restart_wave: %0d bad cycles, first %0d got %b want %b", errs, first, s_smp[first], exp_smp[first]);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    logic [7:0] pay[$];
    int errs, first;
    pay = {8'h01, 8'h02, 8'h03, 8'h04};
    qmem = pay;
    drive_q();
    enable = 1'b1;
    exp_smp.delete();
    model_packet(pay, 1'b0);
    capture(2 * SLOT + 13, -1, -1);
    errs = 0; first = -1;
    foreach (s_smp[i]) if (s_smp[i] !== exp_smp[i]) begin if (first < 0) first = i; errs++; end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL rst_prefix_wave: %0d bad cycles, first %0d got %b want %b", errs, first, s_smp[first], exp_smp[first]);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({laser_out, busy, qif.q_read} !== 3'b100) begin
      n_fail++;
      $display("FAIL rst_async: laser/busy/q_read got %b want 100", {laser_out, busy, qif.q_read});
    end
    n_checks++;
    if (qmem.size() != 2) begin
      n_fail++;
      $display("FAIL rst_popped: %0d bytes left, want 2", qmem.size());
    end
    @(negedge clock);
    @(negedge clock);
    qmem.push_back(8'h05);
    qmem.push_back(8'h06);
    drive_q();
    pay = {8'h03, 8'h04, 8'h05, 8'h06};
    exp_smp.delete();
    model_packet(pay, 1'b0);
    reset_n = 1'b1;
    capture(exp_smp.size(), -1, -1);
    enable = 1'b0;
    errs = 0; first = -1;
    foreach (exp_smp[i]) if (s_smp[i] !== exp_smp[i]) begin if (first < 0) first = i; errs++; end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL rst_fresh_wave: %0d bad cycles, first %0d got %b want %b", errs, first, s_smp[first], exp_smp[first]);
    end
    wait_idle();
  endtask

  task automatic test_checksum_zero();
    logic [7:0] pay[$];
    logic [7:0] dec;
    logic [4:0] smp;
    int errs, first;
    pay = {8'hFF, 8'h00, 8'hFF, 8'h00};
    qmem = pay;
    drive_q();
    enable = 1'b1;
    exp_smp.delete();
    model_packet(pay, 1'b0);
    capture(exp_smp.size(), -1, -1);
    enable = 1'b0;
    errs = 0; first = -1;
    foreach (exp_smp[i]) if (s_smp[i] !== exp_smp[i]) begin if (first < 0) first = i; errs++; end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL cksum_wave: %0d bad cycles, first %0d got %b want %b", errs, first, s_smp[first], exp_smp[first]);
    end
    // Decode the first payload frame and the checksum frame mid-bit.
    for (int f = 1; f <= 5; f += 4) begin
      dec = 8'h00;
      for (int b = 1; b <= 8; b++) begin
        smp = s_smp[f * SLOT + 1 + b * CPB + CPB / 2];
        dec = {smp[4], dec[7:1]};
      end
      n_checks++;
      if (dec !== ((f == 1) ? 8'hFF : 8'h00)) begin
        n_fail++;
        $display("FAIL cksum_decode frame %0d: got %h want %h", f, dec, (f == 1) ? 8'hFF : 8'h00);
      end
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] all[$];
    logic [7:0] pay[$];
    int errs, first;
    all.delete();
    for (int i = 0; i < 8; i++) all.push_back(8'($urandom_range(0, 255)));
    qmem = all;
    drive_q();
    enable = 1'b1;
    exp_smp.delete();
    pay.delete();
    for (int i = 0; i < 4; i++) pay.push_back(all[i]);
    model_packet(pay, 1'b0);
    pay.delete();
    for (int i = 4; i < 8; i++) pay.push_back(all[i]);
    model_packet(pay, 1'b0);
    capture(exp_smp.size(), -1, -1);
    enable = 1'b0;
    errs = 0; first = -1;
    foreach (exp_smp[i]) if (s_smp[i] !== exp_smp[i]) begin if (first < 0) first = i; errs++; end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL b2b_wave: %0d bad cycles, first %0d got %b want %b", errs, first, s_smp[first], exp_smp[first]);
    end
    n_checks++;
    if (s_smp[PKT][3] !== 1'b0 || s_smp[PKT + 1][3] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: busy got %b%b want 01", s_smp[PKT][3], s_smp[PKT + 1][3]);
    end
    wait_idle();
  endtask

  task automatic test_random();
    logic [7:0] pay[$];
    int errs, first;
    for (int it = 0; it < 3; it++) begin
      pay.delete();
      for (int i = 0; i < 4; i++) pay.push_back(8'($urandom_range(0, 255)));
      qmem = pay;
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) qmem.push_back(8'($urandom_range(0, 255)));
      drive_q();
      enable = 1'b1;
      exp_smp.delete();
      model_packet(pay, 1'b0);
      capture(exp_smp.size(), -1, -1);
      enable = 1'b0;
      errs = 0; first = -1;
      foreach (exp_smp[i]) if (s_smp[i] !== exp_smp[i]) begin if (first < 0) first = i; errs++; end
      n_checks++;
      if (errs != 0) begin
        n_fail++;
        $display("FAIL random_wave %0d: %0d bad cycles, first %0d got %b want %b", it, errs, first, s_smp[first], exp_smp[first]);
      end
      wait_idle();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    qmem.delete();
    drive_q();
    test_reset();
    test_basic();
    test_idle_hold();
    test_underrun();
    test_enable_drop();
    test_reset_mid();
    test_checksum_zero();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
